// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle for the seven-segment scan decoder: scanned display inputs and decoded outputs.
interface seg7_scan_decoder_if;
  logic [0:6]  SEG;
  logic [3:0]  DIG;
  logic [15:0] Q;
  logic        FRAME;
  logic [3:0]  SEEN;
  logic [3:0]  ERR;

  modport master (output SEG, DIG, input Q, FRAME, SEEN, ERR);
  modport slave  (input SEG, DIG, output Q, FRAME, SEEN, ERR);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed 4-digit active-low 7-segment bus back into a 16-bit value,
// publishing only complete frames; Q updates on the capture edge of the last missing digit.
module seg7_scan_decoder #(
  parameter int unsigned SETTLE = 4
) (
  input logic               Clock,
  input logic               Reset,
  seg7_scan_decoder_if.slave bus
);

  localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  logic [10:0] prev_q, prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stage_q, stage_d;
  logic [15:0] q_q, q_d;
  logic        frame_q, frame_d;
  logic [3:0]  seen_q, seen_d;
  logic [3:0]  err_q, err_d;

  logic [10:0] pair;
  logic [6:0]  seg_vec;
  logic        one_hot, same, capture;
  logic [1:0]  dig_idx;
  logic        pat_vld;
  logic [3:0]  pat_nib;
  logic [15:0] merged;
  logic [3:0]  seen_new;

  assign seg_vec = bus.SEG;
  assign pair    = {bus.DIG, seg_vec};
  assign one_hot = (bus.DIG != 4'd0) && ((bus.DIG & (bus.DIG - 4'd1)) == 4'd0);
  assign same    = (pair == prev_q);
  assign prev_d  = pair;
  // The SETTLE-1 -> SETTLE step only happens once per dwell because cnt saturates.
  assign capture = one_hot && same && (cnt_q == SETTLE_M1);

  always_comb begin
    cnt_d = 4'd0;
    if (one_hot) begin
      if (same) cnt_d = (cnt_q >= SETTLE_C) ? SETTLE_C : cnt_q + 4'd1;
      else      cnt_d = 4'd1;
    end
  end

  always_comb begin
    dig_idx = 2'd3;
    case (bus.DIG)
      4'b0001: dig_idx = 2'd0;
      4'b0010: dig_idx = 2'd1;
      4'b0100: dig_idx = 2'd2;
      default: dig_idx = 2'd3;
    endcase
  end

  // Segment order a..g, 0 = lit.
  always_comb begin
    pat_vld = 1'b1;
    pat_nib = 4'h0;
    case (seg_vec)
      7'b0000001: pat_nib = 4'h0;
      7'b1001111: pat_nib = 4'h1;
      7'b0010010: pat_nib = 4'h2;
      7'b0000110: pat_nib = 4'h3;
      7'b1001100: pat_nib = 4'h4;
      7'b0100100: pat_nib = 4'h5;
      7'b0100000: pat_nib = 4'h6;
      7'b0001111: pat_nib = 4'h7;
      7'b0000000: pat_nib = 4'h8;
      7'b0001100: pat_nib = 4'h9;
      7'b0001000: pat_nib = 4'hA;
      7'b1100000: pat_nib = 4'hB;
      7'b0110001: pat_nib = 4'hC;
      7'b1000010: pat_nib = 4'hD;
      7'b0110000: pat_nib = 4'hE;
      7'b0111000: pat_nib = 4'hF;
      default:    pat_vld = 1'b0;
    endcase
  end

  always_comb begin
    merged = stage_q;
    merged[{dig_idx, 2'b00} +: 4] = pat_nib;
    seen_new = seen_q | bus.DIG;
  end

  always_comb begin
    stage_d = stage_q;
    q_d     = q_q;
    frame_d = 1'b0;
    seen_d  = seen_q;
    err_d   = err_q;
    if (capture) begin
      if (pat_vld) begin
        stage_d = merged;
        if (seen_new == 4'hF) begin
          q_d     = merged;
          frame_d = 1'b1;
          seen_d  = 4'h0;
        end else begin
          seen_d  = seen_new;
        end
      end else begin
        err_d  = err_q | bus.DIG;
        seen_d = seen_q & ~bus.DIG;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      q_q     <= '0;
      frame_q <= 1'b0;
      seen_q  <= '0;
      err_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      q_q     <= q_d;
      frame_q <= frame_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.FRAME = frame_q;
  assign bus.SEEN  = seen_q;
  assign bus.ERR   = err_q;

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive end of a time-multiplexed 4-digit seven-segment display bus: one active-low segment bus, shared by all digits, plus a one-hot digit strobe.
- Waits for each digit's pattern to settle, maps it back to a hex nibble, and assembles a 16-bit value.
- Publishes the 16-bit value only as a complete, tear-free frame; flags unrecognised patterns per digit.
- Used as a display loop-back checker and as a front end for scraping values from display pins.

Parameters:
SETTLE, 4, consecutive clock edges a {DIG,SEG} pair must be held unchanged before it is captured (legal range 2..15)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
SEG  input  [0:6]  segment bus, active-low; SEG[0]=a ... SEG[6]=g
DIG  input  [3:0]  digit strobe, active-high, one-hot; DIG[i] selects nibble i (Q[4i+3:4i])
Q  output  [15:0]  last complete decoded frame
FRAME  output  1  one-cycle pulse on the edge Q is updated
SEEN  output  [3:0]  digits validly captured in the current, incomplete frame
ERR  output  [3:0]  sticky flag per digit: an unrecognised pattern was captured

Behaviour:
Interface and reset
- One clock, Clock; Reset is synchronous and active-high.
- Reset (sampled at a rising edge) clears Q, FRAME, SEEN, ERR, the staging register, the dwell counter and the previous-sample register.
- Reset overrides every other event on that edge, including mid-frame or mid-dwell.

Dwell counter cnt (saturates at SETTLE)
- Each edge compares the current {DIG,SEG} with the previous-edge sample, then updates prev.
- DIG not one-hot (zero or several bits set): cnt <= 0; this is the blanking interval, never captured.
- DIG one-hot and {DIG,SEG} equals prev: cnt <= min(cnt+1, SETTLE).
- DIG one-hot and {DIG,SEG} differs from prev: cnt <= 1.
- Capture event: the edge where cnt goes from SETTLE-1 to SETTLE. This is exactly one capture per uninterrupted dwell, however long the pair is held.

Decode table (a..g, 0 = segment lit)
0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0001100, A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
- Any other pattern is invalid, including all-dark 1111111.
- 1100000 always decodes to 0xB.

Capture on digit i (same edge as the capture event)
- Valid pattern: staging[4i+3:4i] <= nibble; SEEN[i] <= 1. Recapturing a digit already in SEEN overwrites its nibble.
- Invalid pattern: ERR[i] <= 1; SEEN[i] <= 0; staging unchanged.

Frame completion
- If a valid capture makes SEEN all ones on this edge:
  - Q <= staging with the new nibble merged, on that same edge.
  - FRAME <= 1 for that one cycle.
  - SEEN <= 0000.
- Q changes only at frame completion. FRAME is 0 on every other cycle.

Error flags
- ERR clears only on Reset; frame completion does not clear it.

Latency
- Q is valid after the capture edge of the last missing digit.
- This is SETTLE edges after that digit's pair first appears, with no further pipeline delay.

Test Plan:
1. Assert Reset for 2 edges while driving random SEG/DIG -> Q=0x0000, FRAME=0, SEEN=0000, ERR=0000; no capture occurs during Reset.
2. SETTLE=4: DIG=0001, SEG=0000110 held 3 edges, then changed -> SEEN stays 0000. Same pair held 20 edges -> SEEN=0001 after the 4th edge and exactly one capture.
3. Scan digit0=1, digit1=2, digit2=3, digit3=4, each held 5 edges with a 2-edge DIG=0000 gap -> FRAME high for exactly one cycle at digit3's 4th edge, Q=0x4321, SEEN=0000 afterwards.
4. DIG=0100, SEG=1111111 held 4 edges after SEEN=0111 -> ERR=0100, SEEN=0011, Q and FRAME unchanged. Next valid full frame still updates Q; ERR stays 0100.
5. DIG=0011 (multi-hot) with a valid pattern held 10 edges -> no capture, SEEN unchanged. Then 1100000 on DIG=1000 -> nibble 0xB; 0100000 -> nibble 0x6.
6. Reset asserted for one edge when SEEN=0111 and Q=0x4321 -> next cycle Q=0x0000, SEEN=0000, cnt=0. A following full frame of 0xBEEF yields Q=0xBEEF.
